// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Purpose  : I2S / left-justified serial audio receiver. Oversamples the
//            external BCK/WS/DIN pins in the clk domain, recovers 16-bit
//            two's-complement words and emits completed left/right pairs.
// Ports    : clk      - system clock, the only clock
//            resetn   - asynchronous active-low reset
//            i2s_bck  - external bit clock (asynchronous)
//            i2s_ws   - external word select (asynchronous)
//            i2s_din  - external serial data, MSB first (asynchronous)
//            left     - last completed left sample
//            right    - last completed right sample
//            valid    - one-cycle strobe, left/right updated with a new pair
//            err      - one-cycle strobe, a word ended with fewer than 16 bits
//            locked   - high while frames are received correctly
// Params   : DELAY    - 0 left-justified, 1 Philips (MSB on second rise)
//            LEFT_WS  - WS level marking a left-channel word
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int   DELAY   = 0,
    parameter logic LEFT_WS = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i2s_bck,
    input  logic        i2s_ws,
    input  logic        i2s_din,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        valid,
    output logic        err,
    output logic        locked
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Synchronizers plus BCK history
    logic r_bck_s1, r_bck_s2, r_bck_h;
    logic r_ws_s1,  r_ws_s2;
    logic r_din_s1, r_din_s2;

    // Word assembly
    state_t      r_state;
    logic [15:0] r_sr;
    logic [4:0]  r_cnt;
    logic        r_is_left;
    logic        r_ws_prev;
    logic        r_ws_vld;
    logic        r_done;
    logic        r_short;

    // Pairing
    logic        r_pend;
    logic [15:0] r_pend_word;

    logic w_rise;
    logic w_ws_chg;

    assign w_rise   = r_bck_s2 & ~r_bck_h;
    // The first rise after reset only records WS, so a word already in flight
    // at reset release cannot look like a fresh WS edge.
    assign w_ws_chg = w_rise & r_ws_vld & (r_ws_s2 != r_ws_prev);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bck_s1 <= 1'b0;
            r_bck_s2 <= 1'b0;
            r_bck_h  <= 1'b0;
            r_ws_s1  <= 1'b0;
            r_ws_s2  <= 1'b0;
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
        end else begin
            r_bck_s1 <= i2s_bck;
            r_bck_s2 <= r_bck_s1;
            r_bck_h  <= r_bck_s2;
            r_ws_s1  <= i2s_ws;
            r_ws_s2  <= r_ws_s1;
            r_din_s1 <= i2s_din;
            r_din_s2 <= r_din_s1;
        end
    end

    // Word framing FSM; r_done / r_short are one-cycle pulses consumed by the
    // pairing stage on the following edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_UNSYNC;
            r_sr      <= 16'd0;
            r_cnt     <= 5'd0;
            r_is_left <= 1'b0;
            r_ws_prev <= 1'b0;
            r_ws_vld  <= 1'b0;
            r_done    <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_short <= 1'b0;
            if (w_rise) begin
                r_ws_prev <= r_ws_s2;
                r_ws_vld  <= 1'b1;
            end
            if (w_ws_chg) begin
                // SHIFT always means fewer than 16 bits collected: the 16th
                // bit moves the FSM to DONE.
                if (r_state == ST_SHIFT) begin
                    r_short <= 1'b1;
                end
                r_state   <= ST_SHIFT;
                r_is_left <= (r_ws_s2 == LEFT_WS);
                if (DELAY == 0) begin
                    r_sr  <= {15'd0, r_din_s2};
                    r_cnt <= 5'd1;
                end else begin
                    r_cnt <= 5'd0;
                end
            end else if (w_rise && r_state == ST_SHIFT) begin
                r_sr  <= {r_sr[14:0], r_din_s2};
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd15) begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
            end
        end
    end

    // Pairing stage. r_sr and r_is_left are stable here: the next rise that
    // could alter them is several clk cycles away.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            left        <= 16'd0;
            right       <= 16'd0;
            valid       <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_word <= 16'd0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (r_short) begin
                err    <= 1'b1;
                locked <= 1'b0;
                r_pend <= 1'b0;
            end else if (r_done) begin
                if (r_is_left) begin
                    r_pend      <= 1'b1;
                    r_pend_word <= r_sr;
                end else if (r_pend) begin
                    left   <= r_pend_word;
                    right  <= r_sr;
                    valid  <= 1'b1;
                    locked <= 1'b1;
                    r_pend <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx
// Purpose  : Self-checking bench for i2s_rx. One instance runs left-justified
//            framing, one runs Philips framing; both share the pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

    localparam logic c_lw = 1'b1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic i2s_bck = 1'b0;
    logic i2s_ws = 1'b0;
    logic i2s_din = 1'b0;

    logic [15:0] left0, right0, left1, right1;
    logic        valid0, err0, locked0, valid1, err1, locked1;

    i2s_rx #(.DELAY(0), .LEFT_WS(c_lw)) u_dut0 (
        .clk(clk), .resetn(resetn), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws),
        .i2s_din(i2s_din), .left(left0), .right(right0), .valid(valid0),
        .err(err0), .locked(locked0));

    i2s_rx #(.DELAY(1), .LEFT_WS(c_lw)) u_dut1 (
        .clk(clk), .resetn(resetn), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws),
        .i2s_din(i2s_din), .left(left1), .right(right1), .valid(valid1),
        .err(err1), .locked(locked1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        int          c;
        logic        lk;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  errs0 = 0;
    int  errs1 = 0;
    int  err_cyc0 = 0;

    // Strobe monitor
    always @(posedge clk) begin
        #1;
        if (valid0) q0.push_back('{l: left0, r: right0, c: cyc, lk: locked0});
        if (valid1) q1.push_back('{l: left1, r: right1, c: cyc, lk: locked1});
        if (err0) begin errs0++; err_cyc0 = cyc; end
        if (err1) errs1++;
        if (valid0 || err0 || valid1 || err1) begin
            tests++;
            if ((valid0 && err0) || (valid1 && err1)) begin
                fails++;
                $display("FAIL strobe_overlap got v0=%b e0=%b v1=%b e1=%b exp no overlap", valid0, err0, valid1, err1);
            end
        end
    end

    int H = 8;
    int rise_k[32];

    // Sends the top n bits of 'bits' MSB first with WS at 'lvl'. Data and WS
    // change on the BCK fall; rise_k[b] is the clk edge at which the first
    // synchronizer stage captures the rise for bit b.
    task automatic send_bits(input logic lvl, input logic [31:0] bits, input int n);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            i2s_ws  = lvl;
            i2s_din = bits[31-b];
            i2s_bck = 1'b0;
            repeat (H - 1) @(negedge clk);
            @(negedge clk);
            i2s_bck   = 1'b1;
            rise_k[b] = cyc + 1;
            repeat (H - 1) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_mon();
        q0.delete(); q1.delete(); errs0 = 0; errs1 = 0;
    endtask

    function automatic logic [15:0] word_of(input logic [31:0] bits, input int d);
        logic [31:0] s;
        s = bits << d;
        return s[31:16];
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            i2s_bck = 1'($urandom); i2s_ws = 1'($urandom); i2s_din = 1'($urandom);
        end
        tests += 2;
        if ({left0, right0, valid0, err0, locked0} !== 35'd0) begin
            fails++; $display("FAIL reset_dut0 got %h/%h v%b e%b l%b exp all 0", left0, right0, valid0, err0, locked0);
        end
        if ({left1, right1, valid1, err1, locked1} !== 35'd0) begin
            fails++; $display("FAIL reset_dut1 got %h/%h v%b e%b l%b exp all 0", left1, right1, valid1, err1, locked1);
        end
        clear_mon();
        @(negedge clk);
        resetn = 1'b1;
        send_bits(1'b1, $urandom, 24);
        settle();
        tests += 2;
        if (q0.size() + q1.size() !== 0) begin
            fails++; $display("FAIL reset_no_valid got %0d pulses exp 0", q0.size() + q1.size());
        end
        if (errs0 + errs1 !== 0) begin
            fails++; $display("FAIL reset_no_err got %0d pulses exp 0", errs0 + errs1);
        end
    endtask

    task automatic test_nominal();
        ev_t e;
        H = 16;
        send_bits(~c_lw, $urandom, 16);
        clear_mon();
        send_bits(c_lw, 32'h8001_0000, 16);
        tests++;
        if (locked0 !== 1'b0 || q0.size() !== 0) begin
            fails++; $display("FAIL nominal_pre got locked=%b pulses=%0d exp 0/0", locked0, q0.size());
        end
        send_bits(~c_lw, 32'h7FFE_0000, 16);
        settle();
        e = (q0.size() > 0) ? q0[0] : '0;
        tests += 5;
        if (q0.size() !== 1) begin fails++; $display("FAIL nominal_count got %0d exp 1", q0.size()); end
        if (e.l !== 16'h8001 || e.r !== 16'h7FFE) begin
            fails++; $display("FAIL nominal_data got %h/%h exp 8001/7ffe", e.l, e.r);
        end
        if (e.c !== rise_k[15] + 3) begin fails++; $display("FAIL nominal_latency got edge %0d exp %0d", e.c, rise_k[15] + 3); end
        if (e.lk !== 1'b1 || locked0 !== 1'b1) begin fails++; $display("FAIL nominal_locked got %b/%b exp 1", e.lk, locked0); end
        if (left0 !== 16'h8001 || right0 !== 16'h7FFE || errs0 !== 0) begin
            fails++; $display("FAIL nominal_hold got %h/%h errs=%0d exp 8001/7ffe errs=0", left0, right0, errs0);
        end
    endtask

    task automatic test_midword();
        ev_t e;
        H = 8;
        @(negedge clk);
        resetn = 1'b0;
        clear_mon();
        send_bits(~c_lw, $urandom, 5);
        resetn = 1'b1;
        send_bits(~c_lw, $urandom, 11);
        send_bits(c_lw, 32'h1234_0000, 16);
        send_bits(~c_lw, 32'hABCD_0000, 16);
        settle();
        e = (q0.size() > 0) ? q0[0] : '0;
        tests += 2;
        if (errs0 !== 0) begin fails++; $display("FAIL midword_err got %0d exp 0", errs0); end
        if (q0.size() < 1 || e.l !== 16'h1234 || e.r !== 16'hABCD) begin
            fails++; $display("FAIL midword_first got %h/%h (n=%0d) exp 1234/abcd", e.l, e.r, q0.size());
        end
    endtask

    task automatic test_short();
        ev_t e;
        clear_mon();
        send_bits(c_lw, $urandom, 12);
        send_bits(~c_lw, $urandom, 16);
        tests += 3;
        if (errs0 !== 1) begin fails++; $display("FAIL short_err got %0d exp 1", errs0); end
        if (err_cyc0 !== rise_k[0] + 3) begin fails++; $display("FAIL short_err_time got %0d exp %0d", err_cyc0, rise_k[0] + 3); end
        if (locked0 !== 1'b0 || q0.size() !== 0) begin
            fails++; $display("FAIL short_state got locked=%b pulses=%0d exp 0/0", locked0, q0.size());
        end
        send_bits(c_lw, 32'h0F0F_0000, 16);
        send_bits(~c_lw, 32'hF0F0_0000, 16);
        settle();
        e = (q0.size() > 0) ? q0[0] : '0;
        tests += 2;
        if (q0.size() !== 1 || e.l !== 16'h0F0F || e.r !== 16'hF0F0) begin
            fails++; $display("FAIL short_recover got %h/%h (n=%0d) exp 0f0f/f0f0", e.l, e.r, q0.size());
        end
        if (locked0 !== 1'b1 || errs0 !== 1) begin
            fails++; $display("FAIL short_relock got locked=%b errs=%0d exp 1/1", locked0, errs0);
        end
    endtask

    task automatic test_slot32();
        ev_t e;
        logic [31:0] lb, rb;
        clear_mon();
        lb = {16'hCAFE, 16'($urandom)};
        rb = {16'h5A5A, 16'($urandom)};
        send_bits(c_lw, lb, 32);
        send_bits(~c_lw, rb, 32);
        settle();
        e = (q0.size() > 0) ? q0[0] : '0;
        tests += 2;
        if (q0.size() !== 1 || e.l !== 16'hCAFE || e.r !== 16'h5A5A) begin
            fails++; $display("FAIL slot32 got %h/%h (n=%0d) exp cafe/5a5a", e.l, e.r, q0.size());
        end
        if (errs0 !== 0) begin fails++; $display("FAIL slot32_err got %0d exp 0", errs0); end
    endtask

    // Random frames, some with short slots; the model expects a pair for
    // every frame whose two slots both carry at least 16 bits and one err
    // per short slot.
    task automatic test_random();
        ev_t exp_q[$];
        ev_t e, x;
        int  exp_err = 0;
        clear_mon();
        for (int f = 0; f < 12; f++) begin
            logic [31:0] lb, rb;
            int ln, rn;
            H  = $urandom_range(3, 6);
            lb = $urandom; rb = $urandom;
            ln = ($urandom_range(0, 4) == 0 && f < 11) ? $urandom_range(4, 15) : $urandom_range(16, 32);
            rn = ($urandom_range(0, 4) == 0 && f < 11) ? $urandom_range(4, 15) : $urandom_range(16, 32);
            if (ln < 16) exp_err++;
            if (rn < 16) exp_err++;
            if (ln >= 16 && rn >= 16) exp_q.push_back('{l: word_of(lb, 0), r: word_of(rb, 0), c: 0, lk: 1'b1});
            send_bits(c_lw, lb, ln);
            send_bits(~c_lw, rb, rn);
        end
        settle();
        tests += 2;
        if (q0.size() !== exp_q.size()) begin fails++; $display("FAIL random_count got %0d exp %0d", q0.size(), exp_q.size()); end
        if (errs0 !== exp_err) begin fails++; $display("FAIL random_err got %0d exp %0d", errs0, exp_err); end
        while (exp_q.size() > 0 && q0.size() > 0) begin
            x = exp_q.pop_front();
            e = q0.pop_front();
            tests++;
            if (e.l !== x.l || e.r !== x.r) begin
                fails++; $display("FAIL random_pair got %h/%h exp %h/%h", e.l, e.r, x.l, x.r);
            end
        end
        H = 8;
    endtask

    task automatic test_philips();
        ev_t e;
        logic [31:0] lb, rb;
        H = 8;
        send_bits(c_lw, $urandom, 32);
        send_bits(~c_lw, $urandom, 32);
        settle();
        clear_mon();
        lb = {1'b0, 16'h0001, 15'd0};
        rb = {1'b1, 16'hFFFF, 15'd0};
        send_bits(c_lw, lb, 32);
        send_bits(~c_lw, rb, 32);
        settle();
        e = (q1.size() > 0) ? q1[0] : '0;
        tests += 2;
        if (q1.size() !== 1 || e.l !== 16'h0001 || e.r !== 16'hFFFF) begin
            fails++; $display("FAIL philips_pair got %h/%h (n=%0d) exp 0001/ffff", e.l, e.r, q1.size());
        end
        if (errs1 !== 0 || locked1 !== 1'b1) begin
            fails++; $display("FAIL philips_state got errs=%0d locked=%b exp 0/1", errs1, locked1);
        end
        // Reset in the middle of a right word
        send_bits(c_lw, {1'b0, 16'h1111, 15'd0}, 32);
        send_bits(~c_lw, $urandom, 10);
        resetn = 1'b0;
        #1;
        tests++;
        if ({left1, right1, valid1, err1, locked1, left0} !== 51'd0) begin
            fails++; $display("FAIL philips_async_reset got %h/%h l%b (dut0 %h) exp 0", left1, right1, locked1, left0);
        end
        send_bits(~c_lw, $urandom, 6);
        resetn = 1'b1;
        send_bits(~c_lw, $urandom, 16);
        clear_mon();
        lb = {1'b1, 16'($urandom), 15'd0};
        rb = {1'b0, 16'($urandom), 15'd0};
        send_bits(c_lw, lb, 32);
        send_bits(~c_lw, rb, 32);
        settle();
        e = (q1.size() > 0) ? q1[0] : '0;
        tests += 2;
        if (q1.size() !== 1 || e.l !== word_of(lb, 1) || e.r !== word_of(rb, 1)) begin
            fails++; $display("FAIL philips_after_reset got %h/%h (n=%0d) exp %h/%h", e.l, e.r, q1.size(), word_of(lb, 1), word_of(rb, 1));
        end
        if (errs1 !== 0) begin fails++; $display("FAIL philips_after_reset_err got %0d exp 0", errs1); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_midword();
        test_short();
        test_slot32();
        test_random();
        test_philips();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
